shift_reg_sipo: RTL

Serial-in/parallel-out frame receiver, the receive end of the MSB-first serial link driven by our PISO shift register. Collects WIDTH qualified serial bits per frame, beginning at a sync-marked MSB. Presents the assembled word on a registered parallel output with a valid/ready handshake, and flags overrun and framing errors. Sits between the serial pin and the consuming parallel logic.

---
 rtl/sipo_pkg.sv | 14 +
 rtl/shift_reg_sipo_if.sv | 26 ++
 rtl/sipo_out_buf.sv | 42 ++++
 rtl/shift_reg_sipo.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the shift_reg_sipo frame receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_sipo_if.sv
// Serial input, parallel output handshake and status signals of shift_reg_sipo.
interface shift_reg_sipo_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sin;
  logic             sin_en;
  logic             sync;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             ovr_clr;
  logic             par_err;

  modport master (
    output sin, sin_en, sync, pout_ready, ovr_clr,
    input  pout, pout_valid, busy, frame_err, overrun, par_err
  );

  modport slave (
    input  sin, sin_en, sync, pout_ready, ovr_clr,
    output pout, pout_valid, busy, frame_err, overrun, par_err
  );
endinterface

// File: rtl/sipo_out_buf.sv
// Parallel output holding register with valid/ready handshake and sticky overrun.
module sipo_out_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             overrun
);

  logic drain;
  logic room;

  assign drain = pout_valid & ready;
  assign room  = ~pout_valid | drain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit && room) begin
        pout       <= word;
        pout_valid <= 1'b1;
      end else if (drain) begin
        pout_valid <= 1'b0;
      end
      // A fresh overrun in the same cycle as ovr_clr keeps the flag set
      if (commit && !room)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_sipo.sv
// MSB-first serial-in/parallel-out frame receiver with sync, framing and overrun flags.
// Optional even parity bit per frame when SIPO_PARITY_EN is defined.
module shift_reg_sipo
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  shift_reg_sipo_if.slave  bus
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic             frame_err_q;
  logic             commit;
  logic [WIDTH-1:0] commit_word;

  assign shifted = {sh[WIDTH-2:0], bus.sin};
  assign first   = {{(WIDTH-1){1'b0}}, bus.sin};

`ifdef SIPO_PARITY_EN
  logic par_err_q;

  // The word is held in sh during PAR and released only on a parity match
  always_comb begin
    commit      = 1'b0;
    commit_word = sh;
    if (state == PAR && bus.sin_en && !bus.sync && (bus.sin == ^sh))
      commit = 1'b1;
  end

  assign bus.par_err = par_err_q;
`else
  always_comb begin
    commit      = 1'b0;
    commit_word = shifted;
    if (state == SHIFT && bus.sin_en && !bus.sync && cnt == LAST)
      commit = 1'b1;
  end

  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      frame_err_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (bus.sin_en) begin
        case (state)
          IDLE: begin
            if (bus.sync) begin
              sh    <= first;
              cnt   <= CW'(1);
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (bus.sync) begin
              sh          <= first;
              cnt         <= CW'(1);
              frame_err_q <= 1'b1;
            end else begin
              sh <= shifted;
              if (cnt == LAST) begin
                cnt   <= '0;
`ifdef SIPO_PARITY_EN
                state <= PAR;
`else
                state <= IDLE;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
`ifdef SIPO_PARITY_EN
          PAR: begin
            if (bus.sync) begin
              sh          <= first;
              cnt         <= CW'(1);
              frame_err_q <= 1'b1;
              state       <= SHIFT;
            end else begin
              par_err_q <= (bus.sin != ^sh);
              state     <= IDLE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = frame_err_q;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .commit     (commit),
    .word       (commit_word),
    .ready      (bus.pout_ready),
    .ovr_clr    (bus.ovr_clr),
    .pout       (bus.pout),
    .pout_valid (bus.pout_valid),
    .overrun    (bus.overrun)
  );

endmodule
